// File: rtl/hilo_muldiv_sequencer.sv
// Purpose : sequential unsigned MIPS mult/div unit that owns the architectural HI/LO registers.
// Latency : WIDTH iterations; done pulses WIDTH+1 cycles after the start edge, or 1 cycle for divide-by-zero.
// Backpr. : no handshake; start is ignored while busy, so the issuer stalls on busy until done.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start, op             issue request (op 0 = multiply, 1 = divide), sampled in IDLE or DONE
//   operand_a, operand_b  multiplicand/dividend and multiplier/divisor, captured on accepted start
//   busy, done            state RUN / one-cycle state DONE
//   div_by_zero           set with done for a zero divisor, held until the next accepted start
//   hi, lo                architectural HI/LO: product high/low half, or remainder/quotient
module hilo_muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               op_q, op_d;
   logic [CW-1:0]      count_q, count_d;
   logic [WIDTH-1:0]   b_q, b_d;
   // Multiply: full 2W accumulator. Divide: low half holds the quotient Q.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // Stored remainder is always < divisor, so W bits hold it; the (W+1)-bit
   // value only exists transiently after the left shift.
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               dbz_q, dbz_d;

   // One shift-add multiply step.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // One restoring divide step. The shifted remainder is below 2*divisor, so
   // the (W+1)-bit difference borrows (MSB set) exactly when shift < divisor.
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem_next;
   logic [WIDTH-1:0]   div_q_next;

   assign div_shift    = {rem_q, acc_q[WIDTH-1]};
   assign div_diff     = div_shift - {1'b0, b_q};
   assign div_ge       = ~div_diff[WIDTH];
   assign div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_q_next   = {acc_q[WIDTH-2:0], div_ge};

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = count_q;
      b_d     = b_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               op_d    = op;
               b_d     = operand_b;
               count_d = '0;
               dbz_d   = 1'b0;
               rem_d   = '0;
               acc_d   = {{WIDTH{1'b0}}, operand_a};
               if (op && (operand_b == '0)) begin
                  // Zero divisor: skip iteration and commit the fixed result now.
                  state_d = S_DONE;
                  dbz_d   = 1'b1;
                  hi_d    = operand_a;
                  lo_d    = '1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end

         S_RUN: begin
            count_d = count_q + 1'b1;
            if (op_q) begin
               rem_d = div_rem_next;
               acc_d = {{WIDTH{1'b0}}, div_q_next};
            end else begin
               acc_d = mul_next;
            end
            // HI/LO only move on the final iteration, from that step's result.
            if (count_q == LAST_ITER) begin
               state_d = S_DONE;
               if (op_q) begin
                  hi_d = div_rem_next;
                  lo_d = div_q_next;
               end else begin
                  hi_d = mul_next[2*WIDTH-1:WIDTH];
                  lo_d = mul_next[WIDTH-1:0];
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         count_q <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Purpose : directed self-checking bench for hilo_muldiv_sequencer (WIDTH=32).
// Latency : checks done at cycle WIDTH+1 after the start edge, or cycle 1 for divide-by-zero.
// Backpr. : exercises start ignored during RUN and back-to-back issue in the DONE cycle.
module tb_hilo_muldiv_sequencer;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         op;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int total;
   int bad;

   hilo_muldiv_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive a request, let the start edge (E0) take it, drop start. Returns in cycle 1.
   task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Called in cycle 1; walks cycles until done (bounded). Tracks busy cycles,
   // HI/LO movement before done, and busy/done overlap. Optionally fires
   // spurious start pulses with different operands while the unit is running.
   task automatic wait_done(input logic [W-1:0] hi_prev, input logic [W-1:0] lo_prev,
                            input bit noise, output int cyc, output int busy_cnt,
                            output int hold_bad, output int both_bad);
      cyc      = 1;
      busy_cnt = 0;
      hold_bad = 0;
      both_bad = 0;
      while (cyc < 100) begin
         if (busy && done) both_bad++;
         if (done) break;
         if (busy) busy_cnt++;
         if (hi !== hi_prev || lo !== lo_prev) hold_bad++;
         if (noise && (cyc == 5 || cyc == 10)) begin
            start     = 1'b1;
            op        = 1'b1;
            operand_a = 32'd99;
            operand_b = 32'd5;
         end else if (noise) begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
   endtask

   int cyc, bcnt, hbad, obad;

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      op        = 1'b0;
      operand_a = '0;
      operand_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dbz",  64'(div_by_zero), 64'd0);
      chk("rst_hi",   64'(hi), 64'd0);
      chk("rst_lo",   64'(lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 7 * 6
      issue(1'b0, 32'd7, 32'd6);
      wait_done(32'd0, 32'd0, 1'b0, cyc, bcnt, hbad, obad);
      chk("mul7x6_cyc",  64'(cyc), 64'd33);
      chk("mul7x6_busy", 64'(bcnt), 64'd32);
      chk("mul7x6_hold", 64'(hbad), 64'd0);
      chk("mul7x6_ovl",  64'(obad), 64'd0);
      chk("mul7x6_lo",   64'(lo), 64'd42);
      chk("mul7x6_hi",   64'(hi), 64'd0);
      chk("mul7x6_dbz",  64'(div_by_zero), 64'd0);
      @(posedge clk);
      #1;
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);

      // max * max
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(32'd0, 32'd42, 1'b0, cyc, bcnt, hbad, obad);
      chk("mulmax_cyc",  64'(cyc), 64'd33);
      chk("mulmax_hold", 64'(hbad), 64'd0);
      chk("mulmax_hi",   64'(hi), 64'hFFFF_FFFE);
      chk("mulmax_lo",   64'(lo), 64'h0000_0001);
      @(posedge clk);
      #1;

      // 100 / 7
      issue(1'b1, 32'd100, 32'd7);
      wait_done(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, cyc, bcnt, hbad, obad);
      chk("div100_cyc",  64'(cyc), 64'd33);
      chk("div100_hold", 64'(hbad), 64'd0);
      chk("div100_lo",   64'(lo), 64'd14);
      chk("div100_hi",   64'(hi), 64'd2);
      chk("div100_dbz",  64'(div_by_zero), 64'd0);
      @(posedge clk);
      #1;

      // 0x80000000 / 0xFFFFFFFF
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(32'd2, 32'd14, 1'b0, cyc, bcnt, hbad, obad);
      chk("divbig_lo", 64'(lo), 64'd0);
      chk("divbig_hi", 64'(hi), 64'h8000_0000);
      @(posedge clk);
      #1;

      // 5 / 0
      issue(1'b1, 32'd5, 32'd0);
      wait_done(32'h8000_0000, 32'd0, 1'b0, cyc, bcnt, hbad, obad);
      chk("dbz_cyc", 64'(cyc), 64'd1);
      chk("dbz_hi",  64'(hi), 64'd5);
      chk("dbz_lo",  64'(lo), 64'hFFFF_FFFF);
      chk("dbz_flag", 64'(div_by_zero), 64'd1);
      @(posedge clk);
      #1;
      chk("dbz_hold_idle", 64'(div_by_zero), 64'd1);

      // 3 * 4 with start pulses during RUN; accepting it clears div_by_zero
      issue(1'b0, 32'd3, 32'd4);
      chk("dbz_clear", 64'(div_by_zero), 64'd0);
      wait_done(32'd5, 32'hFFFF_FFFF, 1'b1, cyc, bcnt, hbad, obad);
      chk("mul3x4_cyc", 64'(cyc), 64'd33);
      chk("mul3x4_lo",  64'(lo), 64'd12);
      chk("mul3x4_hi",  64'(hi), 64'd0);

      // 9 / 2 issued in the DONE cycle: no IDLE bubble
      issue(1'b1, 32'd9, 32'd2);
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_done", 64'(done), 64'd0);
      wait_done(32'd0, 32'd12, 1'b0, cyc, bcnt, hbad, obad);
      chk("div9_cyc", 64'(cyc), 64'd33);
      chk("div9_lo",  64'(lo), 64'd4);
      chk("div9_hi",  64'(hi), 64'd1);
      @(posedge clk);
      #1;

      // Reset in cycle 10 of a multiply
      issue(1'b0, 32'd5, 32'd5);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_hi",   64'(hi), 64'd0);
      chk("arst_lo",   64'(lo), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_done", 64'(done), 64'd0);

      issue(1'b0, 32'd2, 32'd2);
      wait_done(32'd0, 32'd0, 1'b0, cyc, bcnt, hbad, obad);
      chk("mul2x2_cyc", 64'(cyc), 64'd33);
      chk("mul2x2_lo",  64'(lo), 64'd4);
      chk("mul2x2_hi",  64'(hi), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
